alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin arbiter sharing one external combinational ALU between two
//   requesters. A grant latches the winner's operands. The ALU result is
//   captured one cycle later and then held as a response until the consumer
//   accepts it. op_count counts completed operations and saturates at 16'hFFFF.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   req_valid[1:0]          per-requester request valid
//   req_a0/b0/sel0          requester 0 operands and opcode
//   req_a1/b1/sel1          requester 1 operands and opcode
//   req_ready[1:0]          per-requester accept strobe (combinational, IDLE only)
//   alu_a/alu_b/alu_sel     operands and opcode to the shared ALU (registered)
//   alu_out/alu_carry       combinational ALU result
//   rsp_valid/rsp_id        response valid and requester index
//   rsp_out/rsp_carry       captured ALU result and carry
//   rsp_ready               consumer accepts the response
//   op_count[15:0]          saturating completed-operation counter
module alu_arbiter #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [SEL_W-1:0] req_sel0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [SEL_W-1:0] req_sel1,
  output logic [1:0]       req_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_carry,
  input  logic             rsp_ready,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e           state_q,     state_d;
  logic             rr_ptr_q,    rr_ptr_d;
  logic [WIDTH-1:0] op_a_q,      op_a_d;
  logic [WIDTH-1:0] op_b_q,      op_b_d;
  logic [SEL_W-1:0] op_sel_q,    op_sel_d;
  logic             rsp_id_q,    rsp_id_d;
  logic [WIDTH-1:0] rsp_out_q,   rsp_out_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic [15:0]      op_count_q,  op_count_d;

  logic grant_en;
  logic grant_id;

  // On contention rr_ptr picks the winner; otherwise the only valid requester.
  assign grant_en = (state_q == IDLE) && (req_valid != 2'b00);
  assign grant_id = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];

  // rst_n gating keeps req_ready low while reset is held, even though the
  // state is already IDLE.
  always_comb begin
    req_ready = 2'b00;
    if (rst_n && grant_en) begin
      req_ready = grant_id ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_sel_d    = op_sel_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_carry_d = rsp_carry_q;
    op_count_d  = op_count_q;
    case (state_q)
      IDLE: begin
        if (grant_en) begin
          op_a_d   = grant_id ? req_a1   : req_a0;
          op_b_d   = grant_id ? req_b1   : req_b0;
          op_sel_d = grant_id ? req_sel1 : req_sel0;
          rsp_id_d = grant_id;
          rr_ptr_d = ~grant_id;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        rsp_out_d   = alu_out;
        rsp_carry_d = alu_carry;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          if (op_count_q != 16'hFFFF) begin
            op_count_d = op_count_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sel_q    <= '0;
      rsp_id_q    <= 1'b0;
      rsp_out_q   <= '0;
      rsp_carry_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_sel_q    <= op_sel_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_carry_q <= rsp_carry_d;
      op_count_q  <= op_count_d;
    end
  end

  assign alu_a     = op_a_q;
  assign alu_b     = op_b_q;
  assign alu_sel   = op_sel_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_carry = rsp_carry_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Scoreboard bench for alu_arbiter with a behavioural ALU attached
//   (sel 0 = A+B with carry, sel 1 = A-B with borrow as carry).
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [7:0]  req_a0, req_b0, req_a1, req_b1;
  logic [3:0]  req_sel0, req_sel1;
  logic [1:0]  req_ready;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic        alu_carry;
  logic        rsp_valid, rsp_id, rsp_carry, rsp_ready;
  logic [7:0]  rsp_out;
  logic [15:0] op_count;

  typedef struct packed {
    logic       id;
    logic [7:0] out;
    logic       carry;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [15:0] exp_count;
  logic        tb_rr;

  alu_arbiter #(.WIDTH(8), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_a0(req_a0), .req_b0(req_b0), .req_sel0(req_sel0),
    .req_a1(req_a1), .req_b1(req_b1), .req_sel1(req_sel1),
    .req_ready(req_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_carry(rsp_carry),
    .rsp_ready(rsp_ready), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU
  always_comb begin
    alu_out   = '0;
    alu_carry = 1'b0;
    case (alu_sel)
      4'h0: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      4'h1: begin
        alu_out   = alu_a - alu_b;
        alu_carry = (alu_a < alu_b);
      end
      default: ;
    endcase
  end

  function automatic exp_t model(logic id, logic [7:0] a, logic [7:0] b, logic [3:0] sel);
    exp_t r;
    logic [8:0] s;
    r.id = id; r.out = '0; r.carry = 1'b0;
    if (sel == 4'h0) begin
      s = {1'b0, a} + {1'b0, b};
      r.out = s[7:0]; r.carry = s[8];
    end else if (sel == 4'h1) begin
      r.out = a - b; r.carry = (a < b);
    end
    return r;
  endfunction

  // Advance one clock; inputs change 2 time units after the rising edge.
  task automatic step;
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic settle;
    #1;
  endtask

  // Bounded wait for rsp_valid; returns at a sample point.
  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step; settle;
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    req_a0 = 8'h5A; req_b0 = 8'hA5; req_sel0 = 4'h1;
    req_a1 = 8'h3C; req_b1 = 8'hC3; req_sel1 = 4'h0;
    step; step; settle;
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if ({rsp_id, rsp_out, rsp_carry} !== 10'd0) begin n_bad++; $display("FAIL reset_rsp: got id=%b out=%h c=%b want 0/00/0", rsp_id, rsp_out, rsp_carry); end
    n_cmp++; if ({alu_a, alu_b, alu_sel} !== 20'd0) begin n_bad++; $display("FAIL reset_alu: got a=%h b=%h sel=%h want 0", alu_a, alu_b, alu_sel); end
    n_cmp++; if (op_count !== 16'h0000) begin n_bad++; $display("FAIL reset_op_count: got %h want 0000", op_count); end
    req_valid = 2'b00;
    step;
    rst_n = 1'b1;
    step;
    exp_count = 16'h0000; tb_rr = 1'b0;
  endtask

  task automatic test_single;
    exp_t e;
    req_a0 = 8'h0F; req_b0 = 8'h0A; req_sel0 = 4'h0; rsp_ready = 1'b1;
    req_valid = 2'b01;
    settle;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL single_grant: got %b want 01", req_ready); end
    exp_q.push_back('{id: 1'b0, out: 8'h19, carry: 1'b0});
    tb_rr = 1'b1;
    step;
    // Inputs scrambled after the grant must not disturb the in-flight op.
    req_valid = 2'b00; req_a0 = 8'hAA; req_b0 = 8'h55; req_sel0 = 4'h1;
    settle;
    n_cmp++; if ({req_ready, rsp_valid} !== 3'b000) begin n_bad++; $display("FAIL single_issue: got ready=%b valid=%b want 00/0", req_ready, rsp_valid); end
    n_cmp++; if ({alu_a, alu_b, alu_sel} !== {8'h0F, 8'h0A, 4'h0}) begin n_bad++; $display("FAIL single_alu_hold: got %h %h %h want 0f 0a 0", alu_a, alu_b, alu_sel); end
    step; settle;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL single_latency: got rsp_valid=%b want 1", rsp_valid); end
    if (exp_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL single_rsp: got response with empty scoreboard want entry"); end
    else begin
      e = exp_q.pop_front();
      n_cmp++; if ({rsp_id, rsp_out, rsp_carry} !== e) begin n_bad++; $display("FAIL single_rsp: got id=%b out=%h c=%b want id=%b out=%h c=%b", rsp_id, rsp_out, rsp_carry, e.id, e.out, e.carry); end
    end
    step; settle;
    exp_count = 16'd1;
    n_cmp++; if ({rsp_valid, op_count} !== {1'b0, exp_count}) begin n_bad++; $display("FAIL single_done: got valid=%b cnt=%h want 0/%h", rsp_valid, op_count, exp_count); end
  endtask

  task automatic test_carry;
    exp_t e;
    bit ok;
    req_a1 = 8'hFF; req_b1 = 8'h02; req_sel1 = 4'h0;
    req_valid = 2'b10;
    settle;
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL carry_grant: got %b want 10", req_ready); end
    exp_q.push_back('{id: 1'b1, out: 8'h01, carry: 1'b1});
    tb_rr = 1'b0;
    step;
    req_valid = 2'b00;
    wait_rsp(ok);
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL carry_timeout: got no rsp_valid want rsp_valid within 10 cycles"); end
    else if (exp_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL carry_rsp: got response with empty scoreboard want entry"); end
    else begin
      e = exp_q.pop_front();
      n_cmp++; if ({rsp_id, rsp_out, rsp_carry} !== e) begin n_bad++; $display("FAIL carry_rsp: got id=%b out=%h c=%b want id=%b out=%h c=%b", rsp_id, rsp_out, rsp_carry, e.id, e.out, e.carry); end
    end
    step; settle;
    exp_count = exp_count + 16'd1;
    n_cmp++; if (op_count !== exp_count) begin n_bad++; $display("FAIL carry_count: got %h want %h", op_count, exp_count); end
  endtask

  task automatic test_contention;
    exp_t e;
    bit ok;
    int last_cyc;
    logic [1:0] want;
    req_a0 = 8'h30; req_b0 = 8'h12; req_sel0 = 4'h1;
    req_a1 = 8'h05; req_b1 = 8'h09; req_sel1 = 4'h1;
    rsp_ready = 1'b1; req_valid = 2'b11;
    settle;
    last_cyc = cyc;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 10 && req_ready == 2'b00; k++) begin step; settle; end
      if (req_ready == 2'b00) begin n_cmp++; n_bad++; $display("FAIL cont_timeout: got no grant want grant %0d", i); break; end
      want = tb_rr ? 2'b10 : 2'b01;
      n_cmp++; if (req_ready !== want) begin n_bad++; $display("FAIL cont_grant%0d: got %b want %b", i, req_ready, want); end
      if (i > 0) begin
        n_cmp++; if (cyc - last_cyc != 3) begin n_bad++; $display("FAIL cont_spacing%0d: got %0d want 3", i, cyc - last_cyc); end
      end
      last_cyc = cyc;
      exp_q.push_back(tb_rr ? model(1'b1, req_a1, req_b1, req_sel1) : model(1'b0, req_a0, req_b0, req_sel0));
      tb_rr = ~tb_rr;
      wait_rsp(ok);
      if (!ok) begin n_cmp++; n_bad++; $display("FAIL cont_rsp_timeout%0d: got no rsp_valid want rsp_valid", i); break; end
      if (exp_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL cont_rsp%0d: got response with empty scoreboard want entry", i); end
      else begin
        e = exp_q.pop_front();
        n_cmp++; if ({rsp_id, rsp_out, rsp_carry} !== e) begin n_bad++; $display("FAIL cont_rsp%0d: got id=%b out=%h c=%b want id=%b out=%h c=%b", i, rsp_id, rsp_out, rsp_carry, e.id, e.out, e.carry); end
      end
      if (i == 3) req_valid = 2'b00;
      step; settle;
      exp_count = exp_count + 16'd1;
    end
    req_valid = 2'b00;
    n_cmp++; if (op_count !== exp_count) begin n_bad++; $display("FAIL cont_count: got %h want %h", op_count, exp_count); end
  endtask

  task automatic test_backpressure;
    exp_t e;
    rsp_ready = 1'b0;
    req_a0 = 8'h80; req_b0 = 8'h80; req_sel0 = 4'h0;
    req_a1 = 8'h11; req_b1 = 8'h22; req_sel1 = 4'h0;
    req_valid = 2'b01;
    settle;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_grant: got %b want 01", req_ready); end
    exp_q.push_back('{id: 1'b0, out: 8'h00, carry: 1'b1});
    tb_rr = 1'b1;
    step;
    req_valid = 2'b10;
    step; settle;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_out, rsp_carry, req_ready} !== {1'b1, 1'b0, 8'h00, 1'b1, 2'b00}) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got valid=%b id=%b out=%h c=%b ready=%b want 1/0/00/1/00", k, rsp_valid, rsp_id, rsp_out, rsp_carry, req_ready);
      end
      step; settle;
    end
    rsp_ready = 1'b1; req_valid = 2'b00;
    settle;
    if (exp_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL bp_rsp: got response with empty scoreboard want entry"); end
    else begin
      e = exp_q.pop_front();
      n_cmp++; if ({rsp_valid, rsp_id, rsp_out, rsp_carry} !== {1'b1, e}) begin n_bad++; $display("FAIL bp_rsp: got v=%b id=%b out=%h c=%b want 1 id=%b out=%h c=%b", rsp_valid, rsp_id, rsp_out, rsp_carry, e.id, e.out, e.carry); end
    end
    step; settle;
    exp_count = exp_count + 16'd1;
    n_cmp++; if ({rsp_valid, op_count} !== {1'b0, exp_count}) begin n_bad++; $display("FAIL bp_done: got valid=%b cnt=%h want 0/%h", rsp_valid, op_count, exp_count); end
  endtask

  task automatic test_reset_midop;
    exp_t e;
    bit ok;
    rsp_ready = 1'b1;
    req_a0 = 8'h33; req_b0 = 8'h44; req_sel0 = 4'h0;
    req_valid = 2'b01;
    settle;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rst_mid_grant: got %b want 01", req_ready); end
    step;
    req_valid = 2'b00;
    rst_n = 1'b0;
    settle;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_id, rsp_out, rsp_carry, alu_a, alu_b, alu_sel, op_count} !== 49'd0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got rdy=%b v=%b id=%b out=%h c=%b a=%h b=%h sel=%h cnt=%h want all 0",
               req_ready, rsp_valid, rsp_id, rsp_out, rsp_carry, alu_a, alu_b, alu_sel, op_count);
    end
    step; step;
    rst_n = 1'b1;
    tb_rr = 1'b0; exp_count = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      step; settle;
      n_cmp++; if ({rsp_valid, op_count} !== 17'd0) begin n_bad++; $display("FAIL rst_mid_quiet%0d: got valid=%b cnt=%h want 0/0000", k, rsp_valid, op_count); end
    end
    // First contention after reset must favour requester 0.
    req_a0 = 8'h10; req_b0 = 8'h20; req_sel0 = 4'h0;
    req_a1 = 8'h01; req_b1 = 8'h02; req_sel1 = 4'h1;
    req_valid = 2'b11;
    settle;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rst_first_grant: got %b want 01", req_ready); end
    exp_q.push_back('{id: 1'b0, out: 8'h30, carry: 1'b0});
    tb_rr = 1'b1;
    step;
    req_valid = 2'b00;
    wait_rsp(ok);
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL rst_first_timeout: got no rsp_valid want rsp_valid"); end
    else if (exp_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL rst_first_rsp: got response with empty scoreboard want entry"); end
    else begin
      e = exp_q.pop_front();
      n_cmp++; if ({rsp_id, rsp_out, rsp_carry} !== e) begin n_bad++; $display("FAIL rst_first_rsp: got id=%b out=%h c=%b want id=%b out=%h c=%b", rsp_id, rsp_out, rsp_carry, e.id, e.out, e.carry); end
    end
    step; settle;
    exp_count = 16'd1;
    n_cmp++; if (op_count !== exp_count) begin n_bad++; $display("FAIL rst_first_count: got %h want %h", op_count, exp_count); end
  endtask

  task automatic test_saturation;
    exp_t e;
    bit ok;
    logic [15:0] sat_exp [3];
    sat_exp[0] = 16'hFFFE; sat_exp[1] = 16'hFFFF; sat_exp[2] = 16'hFFFF;
    rsp_ready = 1'b1;
    force dut.op_count_q = 16'hFFFD;
    #1;
    release dut.op_count_q;
    for (int i = 0; i < 3; i++) begin
      req_a0 = 8'(i * 3); req_b0 = 8'h01; req_sel0 = 4'h0;
      req_valid = 2'b01;
      settle;
      n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL sat_grant%0d: got %b want 01", i, req_ready); end
      exp_q.push_back(model(1'b0, req_a0, req_b0, req_sel0));
      tb_rr = 1'b1;
      step;
      req_valid = 2'b00;
      wait_rsp(ok);
      if (!ok) begin n_cmp++; n_bad++; $display("FAIL sat_timeout%0d: got no rsp_valid want rsp_valid", i); break; end
      if (exp_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL sat_rsp%0d: got response with empty scoreboard want entry", i); end
      else begin
        e = exp_q.pop_front();
        n_cmp++; if ({rsp_id, rsp_out, rsp_carry} !== e) begin n_bad++; $display("FAIL sat_rsp%0d: got id=%b out=%h c=%b want id=%b out=%h c=%b", i, rsp_id, rsp_out, rsp_carry, e.id, e.out, e.carry); end
      end
      step; settle;
      n_cmp++; if (op_count !== sat_exp[i]) begin n_bad++; $display("FAIL sat_count%0d: got %h want %h", i, op_count, sat_exp[i]); end
    end
    repeat (3) step;
    settle;
    n_cmp++; if (op_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold: got %h want ffff", op_count); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    req_a0 = '0; req_b0 = '0; req_sel0 = '0;
    req_a1 = '0; req_b1 = '0; req_sel1 = '0;
    exp_count = '0; tb_rr = 1'b0;
    test_reset;
    test_single;
    test_carry;
    test_contention;
    test_backpressure;
    test_reset_midop;
    test_saturation;
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running want finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
